diff_adc_model: RTL

- Behavioural-but-synthesizable differential ADC model that sits directly downstream of the bench signal generator.
- Consumes the generator's P/N microvolt buses and samples them at a divided rate.
- Converts each sample with a bit-serial SAR sequence and presents signed codes over a valid/ready interface to the DSP chain under test.
- Flags clipping and consumer overruns.

---
 rtl/diff_adc_model.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/diff_adc_model.sv
// Differential ADC model: divided-rate sampling, scale/clamp, bit-serial SAR, valid/ready output.
// Optional common-mode monitor (cm_fault_o) enabled by defining DIFF_ADC_CM_MONITOR_EN.
module diff_adc_model #(
   parameter int BITS      = 14,
   parameter int FS_UV     = 1000000,
   parameter int CLK_DIV   = 16,
   parameter int CM_MIN_UV = 0,
   parameter int CM_MAX_UV = 2000000
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   en_i,
   input  logic signed [31:0]     sig_p_uv_i,
   input  logic signed [31:0]     sig_n_uv_i,
   output logic [BITS-1:0]        data_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic                   clip_o,
   output logic                   overrun_o,
   output logic [15:0]            overrun_cnt_o
`ifdef DIFF_ADC_CM_MONITOR_EN
   ,
   output logic                   cm_fault_o
`endif
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int K_W   = (BITS > 1) ? $clog2(BITS) : 1;

   localparam logic signed [63:0] FS_S   = 64'(FS_UV);
   localparam logic signed [63:0] S_MAX  = 64'((2 ** (BITS - 1)) - 1);
   localparam logic signed [63:0] S_MIN  = -64'(2 ** (BITS - 1));
   localparam logic signed [63:0] OFFSET = 64'(2 ** (BITS - 1));
   localparam logic [BITS-1:0]    ONE    = BITS'(1);
   localparam logic [BITS-1:0]    MSB    = ONE << (BITS - 1);

   generate
      if (CLK_DIV < BITS + 2) begin : g_div_check
         $error("diff_adc_model: CLK_DIV must be >= BITS+2");
      end
      if (CM_MIN_UV > CM_MAX_UV) begin : g_cm_check
         $error("diff_adc_model: CM_MIN_UV must not exceed CM_MAX_UV");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, SCALE, CONVERT} state_t;

   state_t                state_reg;
   logic [DIV_W-1:0]      div_cnt_reg;
   logic signed [32:0]    diff_reg;
   logic [BITS-1:0]       u_reg;
   logic [BITS-1:0]       result_reg;
   logic [K_W-1:0]        k_reg;
   logic                  clip_int_reg;
   logic [BITS-1:0]       data_reg;
   logic                  valid_reg;
   logic                  clip_reg;
   logic                  overrun_reg;
   logic [15:0]           overrun_cnt_reg;

   logic                  tick;
   logic signed [63:0]    diff_ext;
   logic signed [63:0]    scaled;
   logic [BITS-1:0]       trial;
   logic [BITS-1:0]       result_next;

   assign tick     = (div_cnt_reg == '0) && en_i;
   assign diff_ext = {{31{diff_reg[32]}}, diff_reg};
   // Signed division truncates toward zero, which is the required rounding.
   assign scaled   = (diff_ext <<< (BITS - 1)) / FS_S;
   assign trial       = result_reg | (ONE << k_reg);
   assign result_next = (trial <= u_reg) ? trial : result_reg;

   always_ff @(posedge clk_i) begin
      if (reset_i || !en_i) begin
         div_cnt_reg <= '0;
      end else if (div_cnt_reg == DIV_W'(CLK_DIV - 1)) begin
         div_cnt_reg <= '0;
      end else begin
         div_cnt_reg <= div_cnt_reg + 1'b1;
      end
   end

`ifdef DIFF_ADC_CM_MONITOR_EN
   localparam logic signed [32:0] CM_MIN = 33'(CM_MIN_UV);
   localparam logic signed [32:0] CM_MAX = 33'(CM_MAX_UV);
   logic signed [32:0] cm_reg;
   logic               cm_fault_reg;

   // Sticky: only reset clears a common-mode excursion.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cm_reg       <= '0;
         cm_fault_reg <= 1'b0;
      end else begin
         if (state_reg == IDLE && tick) begin
            cm_reg <= ($signed({sig_p_uv_i[31], sig_p_uv_i}) +
                       $signed({sig_n_uv_i[31], sig_n_uv_i})) >>> 1;
         end
         if (state_reg == SCALE && (cm_reg < CM_MIN || cm_reg > CM_MAX)) begin
            cm_fault_reg <= 1'b1;
         end
      end
   end
   assign cm_fault_o = cm_fault_reg;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg       <= IDLE;
         diff_reg        <= '0;
         u_reg           <= '0;
         result_reg      <= '0;
         k_reg           <= '0;
         clip_int_reg    <= 1'b0;
         data_reg        <= '0;
         valid_reg       <= 1'b0;
         clip_reg        <= 1'b0;
         overrun_reg     <= 1'b0;
         overrun_cnt_reg <= '0;
      end else begin
         overrun_reg <= 1'b0;
         if (valid_reg && ready_i) begin
            valid_reg <= 1'b0;
         end
         case (state_reg)
            IDLE: begin
               if (tick) begin
                  diff_reg  <= $signed({sig_p_uv_i[31], sig_p_uv_i}) -
                               $signed({sig_n_uv_i[31], sig_n_uv_i});
                  state_reg <= SCALE;
               end
            end
            SCALE: begin
               if (scaled > S_MAX) begin
                  u_reg        <= BITS'(S_MAX + OFFSET);
                  clip_int_reg <= 1'b1;
               end else if (scaled < S_MIN) begin
                  u_reg        <= '0;
                  clip_int_reg <= 1'b1;
               end else begin
                  u_reg        <= BITS'(scaled + OFFSET);
                  clip_int_reg <= 1'b0;
               end
               result_reg <= '0;
               k_reg      <= K_W'(BITS - 1);
               state_reg  <= CONVERT;
            end
            CONVERT: begin
               result_reg <= result_next;
               k_reg      <= k_reg - 1'b1;
               if (k_reg == '0) begin
                  // Offset binary back to two's complement by flipping the MSB.
                  data_reg  <= result_next ^ MSB;
                  clip_reg  <= clip_int_reg;
                  valid_reg <= 1'b1;
                  if (valid_reg && !ready_i) begin
                     overrun_reg <= 1'b1;
                     if (overrun_cnt_reg != 16'hFFFF) begin
                        overrun_cnt_reg <= overrun_cnt_reg + 16'd1;
                     end
                  end
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign data_o        = data_reg;
   assign valid_o       = valid_reg;
   assign clip_o        = clip_reg;
   assign overrun_o     = overrun_reg;
   assign overrun_cnt_o = overrun_cnt_reg;

endmodule
